// File: rtl/decode_stage_pkg.sv
// Shared types and encodings for the RV32I decode stage: opcode/funct7 constants,
// the one-hot instruction flag struct and the immediate format selector.
package decode_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic lui;   logic auipc; logic jal;  logic jalr;
    logic beq;   logic bne;   logic blt;  logic bge;   logic bltu; logic bgeu;
    logic lb;    logic lh;    logic lw;   logic lbu;   logic lhu;
    logic sb;    logic sh;    logic sw;
    logic addi;  logic slti;  logic sltiu; logic xori; logic ori;  logic andi;
    logic slli;  logic srli;  logic srai;
    logic add;   logic sub;   logic sll;  logic slt;   logic sltu;
    logic i_xor; logic srl;   logic sra;  logic i_or;  logic i_and;
  } instructions;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } imm_fmt_e;

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of every non-clock signal around the decode stage: fetch handshake,
// register file read port, writeback forward path and the execute-facing register.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_instr;
  logic [XLEN-1:0]   in_pc;
  logic [4:0]        rf_rs1_idx;
  logic [4:0]        rf_rs2_idx;
  logic [XLEN-1:0]   rf_rs1_v;
  logic [XLEN-1:0]   rf_rs2_v;
  logic              wb_en;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  instructions       out_instr;
  logic [4:0]        out_rd;
  logic [XLEN-1:0]   out_rs1_v;
  logic [XLEN-1:0]   out_rs2_v;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_pc;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, rf_rs1_v, rf_rs2_v,
           wb_en, wb_rd, wb_data, flush, out_ready,
    output in_ready, rf_rs1_idx, rf_rs2_idx, out_valid, out_instr,
           out_rd, out_rs1_v, out_rs2_v, out_imm, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, rf_rs1_v, rf_rs2_v,
           wb_en, wb_rd, wb_data, flush, out_ready,
    input  in_ready, rf_rs1_idx, rf_rs2_idx, out_valid, out_instr,
           out_rd, out_rs1_v, out_rs2_v, out_imm, out_pc, out_illegal
  );

endinterface

// File: rtl/instr_decoder.sv
// Purely combinational RV32I word decoder: one-hot op flags, immediate,
// destination and source register indices, and an illegal-word indication.
module instr_decoder
  import decode_stage_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output instructions     instr_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_idx_o,
  output logic [4:0]      rs2_idx_o,
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  instructions dec;
  imm_fmt_e    fmt;

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign funct7    = instr_i[31:25];
  assign rs1_idx_o = instr_i[19:15];
  assign rs2_idx_o = instr_i[24:20];

  // Any word that sets no flag is illegal, so illegal needs no per-branch bookkeeping.
  always_comb begin
    dec = '0;
    fmt = FMT_R;
    case (opcode)
      OP_LUI:   begin dec.lui = 1'b1;   fmt = FMT_U; end
      OP_AUIPC: begin dec.auipc = 1'b1; fmt = FMT_U; end
      OP_JAL:   begin dec.jal = 1'b1;   fmt = FMT_J; end
      OP_JALR: begin
        fmt = FMT_I;
        if (funct3 == 3'b000) dec.jalr = 1'b1;
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        case (funct3)
          3'b000:  dec.beq  = 1'b1;
          3'b001:  dec.bne  = 1'b1;
          3'b100:  dec.blt  = 1'b1;
          3'b101:  dec.bge  = 1'b1;
          3'b110:  dec.bltu = 1'b1;
          3'b111:  dec.bgeu = 1'b1;
          default: ;
        endcase
      end
      OP_LOAD: begin
        fmt = FMT_I;
        case (funct3)
          3'b000:  dec.lb  = 1'b1;
          3'b001:  dec.lh  = 1'b1;
          3'b010:  dec.lw  = 1'b1;
          3'b100:  dec.lbu = 1'b1;
          3'b101:  dec.lhu = 1'b1;
          default: ;
        endcase
      end
      OP_STORE: begin
        fmt = FMT_S;
        case (funct3)
          3'b000:  dec.sb = 1'b1;
          3'b001:  dec.sh = 1'b1;
          3'b010:  dec.sw = 1'b1;
          default: ;
        endcase
      end
      OP_IMM: begin
        fmt = FMT_I;
        case (funct3)
          3'b000: dec.addi  = 1'b1;
          3'b010: dec.slti  = 1'b1;
          3'b011: dec.sltiu = 1'b1;
          3'b100: dec.xori  = 1'b1;
          3'b110: dec.ori   = 1'b1;
          3'b111: dec.andi  = 1'b1;
          3'b001: begin
            fmt = FMT_SH;
            if (funct7 == F7_ZERO) dec.slli = 1'b1;
          end
          default: begin
            fmt = FMT_SH;
            if (funct7 == F7_ZERO)     dec.srli = 1'b1;
            else if (funct7 == F7_ALT) dec.srai = 1'b1;
          end
        endcase
      end
      OP_REG: begin
        fmt = FMT_R;
        if (funct7 == F7_ZERO) begin
          case (funct3)
            3'b000:  dec.add   = 1'b1;
            3'b001:  dec.sll   = 1'b1;
            3'b010:  dec.slt   = 1'b1;
            3'b011:  dec.sltu  = 1'b1;
            3'b100:  dec.i_xor = 1'b1;
            3'b101:  dec.srl   = 1'b1;
            3'b110:  dec.i_or  = 1'b1;
            default: dec.i_and = 1'b1;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  dec.sub = 1'b1;
            3'b101:  dec.sra = 1'b1;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign illegal_o = ~|dec;
  assign instr_o   = dec;

  always_comb begin
    imm_o = '0;
    rd_o  = instr_i[11:7];
    case (fmt)
      FMT_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_SH:  imm_o = {27'b0, instr_i[24:20]};
      FMT_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:   imm_o = {instr_i[31:12], 12'b0};
      FMT_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
    if (fmt == FMT_S || fmt == FMT_B) rd_o = '0;
    if (illegal_o) begin
      imm_o = '0;
      rd_o  = '0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes the fetched word, resolves operands with
// writeback forwarding, and holds the result in one handshaked output register.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  decode_stage_if.slave  bus
);

  instructions     dec_instr;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rd;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic            dec_illegal;

  logic            valid_q, valid_d;
  instructions     instr_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] pc_q;
  logic            illegal_q;
  logic            in_ready;
  logic            xfer;

  instr_decoder u_dec (
    .instr_i   (bus.in_instr),
    .instr_o   (dec_instr),
    .imm_o     (dec_imm),
    .rd_o      (dec_rd),
    .rs1_idx_o (rs1_idx),
    .rs2_idx_o (rs2_idx),
    .illegal_o (dec_illegal)
  );

  assign in_ready = !valid_q || bus.out_ready;
  assign xfer     = bus.in_valid && in_ready && !bus.flush;

  // x0 reads as zero even when writeback targets it.
  always_comb begin
    rs1_d = bus.rf_rs1_v;
    rs2_d = bus.rf_rs2_v;
    if (rs1_idx == 5'd0)                           rs1_d = '0;
    else if (bus.wb_en && bus.wb_rd == rs1_idx)    rs1_d = bus.wb_data;
    if (rs2_idx == 5'd0)                           rs2_d = '0;
    else if (bus.wb_en && bus.wb_rd == rs2_idx)    rs2_d = bus.wb_data;
  end

  always_comb begin
    valid_d = valid_q;
    if (bus.flush)          valid_d = 1'b0;
    else if (xfer)          valid_d = 1'b1;
    else if (bus.out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (xfer) begin
        instr_q   <= dec_instr;
        rd_q      <= dec_rd;
        rs1_q     <= rs1_d;
        rs2_q     <= rs2_d;
        imm_q     <= dec_imm;
        pc_q      <= bus.in_pc;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.rf_rs1_idx  = rs1_idx;
  assign bus.rf_rs2_idx  = rs2_idx;
  assign bus.out_valid   = valid_q;
  assign bus.out_instr   = instr_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rs1_v   = rs1_q;
  assign bus.out_rs2_v   = rs2_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode/immediate vectors,
// forwarding, reset, backpressure, flush and drain, with hand-computed expectations.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk;
  logic rstn;
  int   errors;
  int   checks;
  instructions expI;

  decode_stage_if bus();

  decode_stage dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc    = pc;
    bus.rf_rs1_v = r1;
    bus.rf_rs2_v = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkInstr(input string tag, input instructions obs, input instructions exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstn = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.rf_rs1_v  = '0;
    bus.rf_rs2_v  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("reset_illegal", {31'b0, bus.out_illegal}, 32'd0);
    checkInstr("reset_instr", bus.out_instr, '0);
    checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("reset_imm", bus.out_imm, 32'd0);
    checkOutput("reset_pc", bus.out_pc, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // addi x1,x2,-1
    applyStimulus(1'b1, 32'hFFF10093, 32'h100, 32'd5, 32'd7);
    #1;
    checkOutput("addi_rs1_idx", {27'b0, bus.rf_rs1_idx}, 32'd2);
    checkOutput("addi_rs2_idx", {27'b0, bus.rf_rs2_idx}, 32'd31);
    tick();
    expI = '0; expI.addi = 1'b1;
    checkOutput("addi_valid", {31'b0, bus.out_valid}, 32'd1);
    checkInstr("addi_instr", bus.out_instr, expI);
    checkOutput("addi_rd", {27'b0, bus.out_rd}, 32'd1);
    checkOutput("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    checkOutput("addi_rs1", bus.out_rs1_v, 32'd5);
    checkOutput("addi_rs2", bus.out_rs2_v, 32'd7);
    checkOutput("addi_pc", bus.out_pc, 32'h100);
    checkOutput("addi_illegal", {31'b0, bus.out_illegal}, 32'd0);

    // asynchronous reset asserted mid-cycle while the register is full
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("mid_reset_valid", {31'b0, bus.out_valid}, 32'd0);
    checkInstr("mid_reset_instr", bus.out_instr, '0);
    checkOutput("mid_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("mid_reset_rs1", bus.out_rs1_v, 32'd0);
    checkOutput("mid_reset_rd", {27'b0, bus.out_rd}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // beq x1,x2,-4
    applyStimulus(1'b1, 32'hFE208EE3, 32'h104, 32'd0, 32'd0);
    tick();
    expI = '0; expI.beq = 1'b1;
    checkInstr("beq_instr", bus.out_instr, expI);
    checkOutput("beq_imm", bus.out_imm, 32'hFFFFFFFC);
    checkOutput("beq_rd", {27'b0, bus.out_rd}, 32'd0);

    // sw x3,8(x4)
    applyStimulus(1'b1, 32'h00322423, 32'h108, 32'd0, 32'd0);
    tick();
    expI = '0; expI.sw = 1'b1;
    checkInstr("sw_instr", bus.out_instr, expI);
    checkOutput("sw_imm", bus.out_imm, 32'd8);
    checkOutput("sw_rd", {27'b0, bus.out_rd}, 32'd0);

    // srai x1,x2,3
    applyStimulus(1'b1, 32'h40315093, 32'h10C, 32'd0, 32'd0);
    tick();
    expI = '0; expI.srai = 1'b1;
    checkInstr("srai_instr", bus.out_instr, expI);
    checkOutput("srai_imm", bus.out_imm, 32'd3);
    checkOutput("srai_rd", {27'b0, bus.out_rd}, 32'd1);

    // lui x5,0x12345
    applyStimulus(1'b1, 32'h123452B7, 32'h110, 32'd0, 32'd0);
    tick();
    expI = '0; expI.lui = 1'b1;
    checkInstr("lui_instr", bus.out_instr, expI);
    checkOutput("lui_imm", bus.out_imm, 32'h12345000);
    checkOutput("lui_rd", {27'b0, bus.out_rd}, 32'd5);

    // all-ones word is not a valid encoding
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h114, 32'd0, 32'd0);
    tick();
    checkOutput("ones_illegal", {31'b0, bus.out_illegal}, 32'd1);
    checkInstr("ones_instr", bus.out_instr, '0);
    checkOutput("ones_rd", {27'b0, bus.out_rd}, 32'd0);
    checkOutput("ones_valid", {31'b0, bus.out_valid}, 32'd1);

    // sub x3,x1,x2
    applyStimulus(1'b1, 32'h402081B3, 32'h118, 32'h11, 32'h22);
    tick();
    expI = '0; expI.sub = 1'b1;
    checkInstr("sub_instr", bus.out_instr, expI);
    checkOutput("sub_rd", {27'b0, bus.out_rd}, 32'd3);
    checkOutput("sub_imm", bus.out_imm, 32'd0);
    checkOutput("sub_rs1", bus.out_rs1_v, 32'h11);
    checkOutput("sub_rs2", bus.out_rs2_v, 32'h22);
    checkOutput("sub_illegal", {31'b0, bus.out_illegal}, 32'd0);

    // funct7=0000001 on OP_REG (M extension) must be rejected
    applyStimulus(1'b1, 32'h022081B3, 32'h11C, 32'd0, 32'd0);
    tick();
    checkOutput("f7_illegal", {31'b0, bus.out_illegal}, 32'd1);
    checkInstr("f7_instr", bus.out_instr, '0);

    // compressed encoding ([1:0]!=11)
    applyStimulus(1'b1, 32'h00000001, 32'h120, 32'd0, 32'd0);
    tick();
    checkOutput("rvc_illegal", {31'b0, bus.out_illegal}, 32'd1);

    // writeback forwarding onto rs1=x2
    applyStimulus(1'b1, 32'hFFF10093, 32'h124, 32'd0, 32'd7);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 5'd2;
    bus.wb_data = 32'hDEADBEEF;
    tick();
    checkOutput("fwd_rs1", bus.out_rs1_v, 32'hDEADBEEF);
    checkOutput("fwd_rs2_no_match", bus.out_rs2_v, 32'd7);

    // addi x1,x0,5 with writeback to x0: operand stays zero
    applyStimulus(1'b1, 32'h00500093, 32'h128, 32'h1234, 32'h99);
    bus.wb_rd = 5'd0;
    tick();
    checkOutput("x0_rs1", bus.out_rs1_v, 32'd0);
    checkOutput("x0_imm", bus.out_imm, 32'd5);
    checkOutput("x0_rs2", bus.out_rs2_v, 32'h99);
    bus.wb_en = 1'b0;

    // backpressure: execute stalls for three cycles
    applyStimulus(1'b1, 32'h123452B7, 32'h200, 32'd0, 32'd0);
    bus.out_ready = 1'b0;
    expI = '0; expI.addi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      checkOutput("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      checkInstr("stall_instr", bus.out_instr, expI);
      checkOutput("stall_imm", bus.out_imm, 32'd5);
      checkOutput("stall_pc", bus.out_pc, 32'h128);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    tick();
    expI = '0; expI.lui = 1'b1;
    checkInstr("release_instr", bus.out_instr, expI);
    checkOutput("release_imm", bus.out_imm, 32'h12345000);
    checkOutput("release_pc", bus.out_pc, 32'h200);
    checkOutput("release_valid", {31'b0, bus.out_valid}, 32'd1);

    // flush drops the concurrent transfer
    applyStimulus(1'b1, 32'h00322423, 32'h204, 32'd0, 32'd0);
    bus.flush = 1'b1;
    tick();
    checkOutput("flush_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("flush_imm_held", bus.out_imm, 32'h12345000);
    checkOutput("flush_pc_held", bus.out_pc, 32'h200);
    bus.flush = 1'b0;

    // drain: consumed with no new input
    applyStimulus(1'b1, 32'hFE208EE3, 32'h208, 32'd0, 32'd0);
    tick();
    checkOutput("refill_valid", {31'b0, bus.out_valid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
    tick();
    checkOutput("drain_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("drain_imm_held", bus.out_imm, 32'hFFFFFFFC);
    checkOutput("drain_in_ready", {31'b0, bus.in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
